// File: rtl/ram_rf_transfer_ctrl_if.sv
// Command and datapath-control bundle between a requester and the RAM/RF transfer sequencer.
// Signal prefixes (i_/o_) are named from the sequencer's point of view.
interface ram_rf_transfer_ctrl_if;
  localparam int unsigned MEM_AW = 8;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned CNT_W  = 5;

  logic              i_start;
  logic              i_op;
  logic [MEM_AW-1:0] i_mem_addr;
  logic [REG_AW-1:0] i_reg_addr;
  logic [CNT_W-1:0]  i_count;

  logic              o_busy;
  logic              o_done;
  logic [MEM_AW-1:0] o_d_addr;
  logic              o_d_w_en;
  logic [REG_AW-1:0] o_rf_w_addr;
  logic              o_rf_w_en;
  logic [REG_AW-1:0] o_rf_ra_addr;

  modport master (
    output i_start, i_op, i_mem_addr, i_reg_addr, i_count,
    input  o_busy, o_done, o_d_addr, o_d_w_en, o_rf_w_addr, o_rf_w_en, o_rf_ra_addr
  );

  modport slave (
    input  i_start, i_op, i_mem_addr, i_reg_addr, i_count,
    output o_busy, o_done, o_d_addr, o_d_w_en, o_rf_w_addr, o_rf_w_en, o_rf_ra_addr
  );
endinterface

// File: rtl/ram_rf_transfer_ctrl.sv
// Burst sequencer moving 1..16 words between data RAM and the register file.
// All outputs are registered copies of what the next state decodes to.
module ram_rf_transfer_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ram_rf_transfer_ctrl_if.slave  bus
);
  localparam int unsigned MEM_AW    = 8;
  localparam int unsigned REG_AW    = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned WAIT_W    = 2;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_ADDR = 3'd1;
  localparam logic [2:0] S_LD_WAIT = 3'd2;
  localparam logic [2:0] S_LD_WB   = 3'd3;
  localparam logic [2:0] S_ST_WR   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        r_state,      w_state_nxt;
  logic [MEM_AW-1:0] r_mem_ptr,    w_mem_ptr_nxt;
  logic [REG_AW-1:0] r_reg_ptr,    w_reg_ptr_nxt;
  logic [CNT_W-1:0]  r_remain,     w_remain_nxt;
  logic [WAIT_W-1:0] r_wait,       w_wait_nxt;
  logic [CNT_W-1:0]  w_count_sat;

  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic [MEM_AW-1:0] r_d_addr,     w_d_addr_nxt;
  logic              r_d_w_en,     w_d_w_en_nxt;
  logic [REG_AW-1:0] r_rf_w_addr,  w_rf_w_addr_nxt;
  logic              r_rf_w_en,    w_rf_w_en_nxt;
  logic [REG_AW-1:0] r_rf_ra_addr, w_rf_ra_addr_nxt;

  // Oversized counts saturate to a full 16-word burst.
  assign w_count_sat = (bus.i_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : bus.i_count;

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_ptr_nxt = r_mem_ptr;
    w_reg_ptr_nxt = r_reg_ptr;
    w_remain_nxt  = r_remain;
    w_wait_nxt    = r_wait;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_mem_ptr_nxt = bus.i_mem_addr;
          w_reg_ptr_nxt = bus.i_reg_addr;
          w_remain_nxt  = w_count_sat;
          if (w_count_sat == '0)  w_state_nxt = S_DONE;
          else if (bus.i_op)      w_state_nxt = S_ST_WR;
          else                    w_state_nxt = S_LD_ADDR;
        end
      end
      S_LD_ADDR: begin
        w_wait_nxt  = WAIT_W'(WAIT_INIT);
        w_state_nxt = (RD_LAT > 1) ? S_LD_WAIT : S_LD_WB;
      end
      S_LD_WAIT: begin
        if (r_wait == '0) w_state_nxt = S_LD_WB;
        else              w_wait_nxt  = r_wait - WAIT_W'(1);
      end
      S_LD_WB, S_ST_WR: begin
        w_mem_ptr_nxt = r_mem_ptr + MEM_AW'(1);
        w_reg_ptr_nxt = r_reg_ptr + REG_AW'(1);
        w_remain_nxt  = r_remain - CNT_W'(1);
        if (r_remain == CNT_W'(1)) w_state_nxt = S_DONE;
        else if (r_state == S_LD_WB) w_state_nxt = S_LD_ADDR;
        else                         w_state_nxt = S_ST_WR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Output registers are loaded with what the upcoming state presents; addresses hold otherwise.
    w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_d_w_en_nxt     = (w_state_nxt == S_ST_WR);
    w_rf_w_en_nxt    = (w_state_nxt == S_LD_WB);
    w_d_addr_nxt     = ((w_state_nxt == S_LD_ADDR) || (w_state_nxt == S_ST_WR)) ? w_mem_ptr_nxt
                                                                                : r_d_addr;
    w_rf_w_addr_nxt  = (w_state_nxt == S_LD_WB) ? w_reg_ptr_nxt : r_rf_w_addr;
    w_rf_ra_addr_nxt = (w_state_nxt == S_ST_WR) ? w_reg_ptr_nxt : r_rf_ra_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_mem_ptr    <= '0;
      r_reg_ptr    <= '0;
      r_remain     <= '0;
      r_wait       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_d_addr     <= '0;
      r_d_w_en     <= 1'b0;
      r_rf_w_addr  <= '0;
      r_rf_w_en    <= 1'b0;
      r_rf_ra_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_ptr    <= w_mem_ptr_nxt;
      r_reg_ptr    <= w_reg_ptr_nxt;
      r_remain     <= w_remain_nxt;
      r_wait       <= w_wait_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_d_addr     <= w_d_addr_nxt;
      r_d_w_en     <= w_d_w_en_nxt;
      r_rf_w_addr  <= w_rf_w_addr_nxt;
      r_rf_w_en    <= w_rf_w_en_nxt;
      r_rf_ra_addr <= w_rf_ra_addr_nxt;
    end
  end

  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_d_addr     = r_d_addr;
  assign bus.o_d_w_en     = r_d_w_en;
  assign bus.o_rf_w_addr  = r_rf_w_addr;
  assign bus.o_rf_w_en    = r_rf_w_en;
  assign bus.o_rf_ra_addr = r_rf_ra_addr;
endmodule

// File: tb/tb_ram_rf_transfer_ctrl.sv
// Bench for ram_rf_transfer_ctrl: a queue-based trace model, RAM/RF datapath model,
// directed scenarios and randomized command stream.
module tb_ram_rf_transfer_ctrl;
  localparam int unsigned RD_LAT = 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       d_w_en;
    logic       rf_w_en;
    logic [7:0] d_addr;
    logic [3:0] rf_w_addr;
    logic [3:0] rf_ra_addr;
  } obs_t;

  logic clk;
  logic rst;
  ram_rf_transfer_ctrl_if bus();

  ram_rf_transfer_ctrl #(.RD_LAT(RD_LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t obs_now();
    return {bus.o_busy, bus.o_done, bus.o_d_w_en, bus.o_rf_w_en,
            bus.o_d_addr, bus.o_rf_w_addr, bus.o_rf_ra_addr};
  endfunction

  // Trace model: on accept, the whole per-cycle output sequence of the command is queued.
  obs_t exp_o;
  obs_t exp_q[$];
  bit   chk_en;

  task automatic build_trace(input logic op, input logic [7:0] mem, input logic [3:0] rg,
                             input logic [4:0] cnt);
    int   n;
    obs_t c;
    n = (cnt > 5'd16) ? 16 : int'(cnt);
    c = exp_o;
    c.done = 1'b0; c.d_w_en = 1'b0; c.rf_w_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      c.busy = 1'b1;
      c.d_addr = mem + 8'(i);
      if (!op) begin
        for (int w = 0; w < int'(RD_LAT); w++) exp_q.push_back(c);
        c.rf_w_en = 1'b1; c.rf_w_addr = rg + 4'(i);
        exp_q.push_back(c);
        c.rf_w_en = 1'b0;
      end else begin
        c.d_w_en = 1'b1; c.rf_ra_addr = rg + 4'(i);
        exp_q.push_back(c);
        c.d_w_en = 1'b0;
      end
    end
    c.busy = 1'b0; c.done = 1'b1;
    exp_q.push_back(c);
  endtask

  initial begin
    chk_en = 1'b0;
    exp_o  = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        exp_o  = '0;
        chk_en = 1'b1;
      end else begin
        if (exp_q.size() == 0 && !exp_o.done && bus.i_start)
          build_trace(bus.i_op, bus.i_mem_addr, bus.i_reg_addr, bus.i_count);
        if (exp_q.size() != 0) exp_o = exp_q.pop_front();
        else begin
          exp_o.busy = 1'b0; exp_o.done = 1'b0; exp_o.d_w_en = 1'b0; exp_o.rf_w_en = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the trace model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("cycle_trace", 32'(obs_now()), 32'(exp_o));
    end
  end

  // External datapath: RAM with one-cycle read latency, RF with async A-side read.
  logic [15:0] ram [256];
  logic [15:0] rf  [16];
  logic [15:0] ram_q;
  logic [15:0] q_nxt;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 16; i++)  rf[i]  = 16'($urandom);
    ram_q = '0;
    forever begin
      @(posedge clk);
      q_nxt = ram[bus.o_d_addr];
      if (bus.o_d_w_en === 1'b1)  ram[bus.o_d_addr] = rf[bus.o_rf_ra_addr];
      if (bus.o_rf_w_en === 1'b1) rf[bus.o_rf_w_addr] = ram_q;
      ram_q = q_nxt;
    end
  end

  logic [7:0] rf_seq[$];
  logic [7:0] d_seq[$];

  function automatic logic [31:0] pack_seq(input logic [7:0] q[$]);
    logic [31:0] p;
    p = {8'(q.size()), 24'hEEEEEE};
    for (int i = 0; i < 3 && i < q.size(); i++) p[23-8*i -: 8] = q[i];
    return p;
  endfunction

  function automatic int exp_lat(input logic op, input logic [4:0] cnt);
    int n;
    n = (cnt > 5'd16) ? 16 : int'(cnt);
    if (n == 0) return 1;
    return op ? n + 1 : n * (int'(RD_LAT) + 1) + 1;
  endfunction

  // Issues one command from an IDLE cycle; returns accept-to-Done latency (-1 on timeout).
  task automatic run_cmd(input logic op, input logic [7:0] mem, input logic [3:0] rg,
                         input logic [4:0] cnt, input bit hold, output int lat);
    rf_seq.delete();
    d_seq.delete();
    bus.i_start = 1'b1; bus.i_op = op; bus.i_mem_addr = mem;
    bus.i_reg_addr = rg; bus.i_count = cnt;
    @(posedge clk); #1;
    if (!hold) bus.i_start = 1'b0;
    bus.i_op = 1'($urandom); bus.i_mem_addr = 8'($urandom);
    bus.i_reg_addr = 4'($urandom); bus.i_count = 5'($urandom);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.o_rf_w_en) rf_seq.push_back(8'(bus.o_rf_w_addr));
      if (bus.o_d_w_en)  d_seq.push_back(bus.o_d_addr);
      if (bus.o_done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int dn;
    logic op;
    logic [7:0] mem;
    logic [3:0] rg;
    logic [4:0] cnt;
    bit hold;
    int n;

    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_op = 1'b0; bus.i_mem_addr = '0;
    bus.i_reg_addr = '0; bus.i_count = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_idle", 32'(obs_now()), 32'h0);
    end
    @(posedge clk); #1;

    // LOAD two words from RAM[0..1] into RF[0..1]
    ram[0] = 16'h0005; ram[1] = 16'h0007; rf[0] = 16'hFFFF; rf[1] = 16'hFFFF;
    run_cmd(1'b0, 8'h00, 4'h0, 5'd2, 1'b0, lat);
    check("load2_latency", 32'(lat), 32'd5);
    check("load2_rf_addrs", pack_seq(rf_seq), 32'h020001EE);
    check("load2_rf_sum", 32'(16'(rf[0] + rf[1])), 32'h000C);

    // STORE across the RAM address wrap
    rf[3] = 16'hBEEF; rf[4] = 16'h1234; ram[8'hFF] = 16'h0; ram[0] = 16'h0;
    run_cmd(1'b1, 8'hFF, 4'h3, 5'd2, 1'b0, lat);
    check("store2_latency", 32'(lat), 32'd3);
    check("store2_ram_addrs", pack_seq(d_seq), 32'h02FF00EE);
    check("store2_ram_data", {ram[8'hFF], ram[8'h00]}, 32'hBEEF1234);

    // LOAD across the RF register wrap
    run_cmd(1'b0, 8'h40, 4'hF, 5'd3, 1'b0, lat);
    check("ldwrap_latency", 32'(lat), 32'd7);
    check("ldwrap_rf_addrs", pack_seq(rf_seq), 32'h030F0001);
    check("ldwrap_rf_data", {rf[15], rf[0]}, {ram[8'h40], ram[8'h41]});

    // Zero-count STORE with Start held through Done: no writes, no re-accept
    run_cmd(1'b1, 8'h20, 4'h2, 5'd0, 1'b1, lat);
    check("cnt0_latency", 32'(lat), 32'd1);
    check("cnt0_no_writes", pack_seq(d_seq), 32'h00EEEEEE);
    @(negedge clk);
    check("cnt0_no_reaccept", 32'({bus.o_busy, bus.o_done}), 32'h0);
    @(posedge clk); #1;

    run_cmd(1'b1, 8'h30, 4'h5, 5'd3, 1'b1, lat);
    check("hold_store_latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("hold_no_reaccept", 32'({bus.o_busy, bus.o_done}), 32'h0);
    @(posedge clk); #1;

    // Count above 16 saturates
    run_cmd(1'b1, 8'hF8, 4'h0, 5'd20, 1'b0, lat);
    check("sat_latency", 32'(lat), 32'd17);
    check("sat_ram_addrs", pack_seq(d_seq), 32'h10F8F9FA);

    // Reset during the third word's RF write-back of an 8-word LOAD
    for (int i = 0; i < 8; i++) begin
      rf[8 + i] = 16'hA5A5;
      ram[8'h10 + 8'(i)] = 16'(16'h1000 + i);
    end
    bus.i_start = 1'b1; bus.i_op = 1'b0; bus.i_mem_addr = 8'h10;
    bus.i_reg_addr = 4'h8; bus.i_count = 5'd8;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_quiet", 32'({bus.o_busy, bus.o_done, bus.o_d_w_en, bus.o_rf_w_en}), 32'h0);
    dn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.o_done) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    check("midrst_words01", {rf[8], rf[9]}, 32'h10001001);
    check("midrst_untouched", {rf[11], rf[15]}, 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Randomized command stream
    for (int t = 0; t < 30; t++) begin
      op   = 1'($urandom_range(0, 1));
      mem  = 8'($urandom);
      rg   = 4'($urandom);
      cnt  = 5'($urandom_range(0, 20));
      hold = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_cmd(op, mem, rg, cnt, hold, lat);
      check("rnd_latency", 32'(lat), 32'(exp_lat(op, cnt)));
      n = (cnt > 5'd16) ? 16 : int'(cnt);
      bad = 0;
      for (int i = 0; i < n; i++)
        if (rf[rg + 4'(i)] !== ram[mem + 8'(i)]) bad++;
      check("rnd_data", 32'(bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
